// File: rtl/fir_stream_controller.sv
// Sequencer for a block-based FIR: loads coefficients, streams NUMB_SAMPLES samples, flushes
// LENGTH-1 zeros and drains the filter latency. Optional macro: FIR_CTRL_COEFF_TIMEOUT_EN.
module fir_stream_controller #(
    parameter int LENGTH       = 20,
    parameter int DATA_WIDTH   = 18,
    parameter int NUMB_SAMPLES = 60,
    parameter int FIR_LATENCY  = 2
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         startBlock,
    input  logic                         dataInValid,
    input  logic signed [DATA_WIDTH-1:0] dataIn,
    input  logic                         coeffSetFlag,
    output logic                         enableFIRCoeff,
    output logic                         loadDataFlag,
    output logic                         stopDataLoadFlag,
    output logic signed [DATA_WIDTH-1:0] firDataIn,
    output logic                         dataOutValid,
    output logic                         busy,
    output logic                         blockDone,
    output logic [7:0]                   sampleCount,
    output logic                         coeffError,
    output logic [2:0]                   stateDbg
);

    // Handshake: a sample is taken on any rising edge in STREAM where dataInValid is high; there
    // is no backpressure, a low dataInValid is simply a stall. loadDataFlag/firDataIn are
    // registered, so an accepted sample appears on firDataIn the cycle after it is taken.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_COEFF = 3'd1,
        S_STREAM     = 3'd2,
        S_FLUSH      = 3'd3,
        S_DRAIN      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam int CNT_MAX = (4 * LENGTH > LENGTH + FIR_LATENCY) ? 4 * LENGTH : LENGTH + FIR_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LENGTH - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(FIR_LATENCY - 1);
    localparam logic [7:0]       NUMB       = 8'(NUMB_SAMPLES);
`ifdef FIR_CTRL_COEFF_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(4 * LENGTH - 1);
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    load_q, load_d;
    logic                    stop_q, stop_d;
    logic [DATA_WIDTH-1:0]   fir_q, fir_d;
    logic [7:0]              count_q, count_d;
    logic                    err_q, err_d;
    logic [FIR_LATENCY-1:0]  vpipe_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        stop_d  = 1'b0;
        fir_d   = fir_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (startBlock) begin
                    state_d = S_LOAD_COEFF;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD_COEFF: begin
                if (coeffSetFlag) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                end
`ifdef FIR_CTRL_COEFF_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    count_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_STREAM: begin
                if (dataInValid) begin
                    load_d  = 1'b1;
                    fir_d   = dataIn;
                    count_d = count_q + 8'd1;
                    // Taking the last sample moves straight on, so sampleCount never exceeds NUMB.
                    if (count_q + 8'd1 == NUMB) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                    end
                end
            end
            S_FLUSH: begin
                load_d = 1'b1;
                fir_d  = '0;
                if (cnt_q == FLUSH_LAST) begin
                    stop_d  = 1'b1;
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            stop_q  <= 1'b0;
            fir_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            stop_q  <= stop_d;
            fir_q   <= fir_d;
            count_q <= count_d;
            err_q   <= err_d;
            // Mirrors the FIR's own pipeline; it keeps shifting regardless of state.
            vpipe_q[0] <= load_q;
            for (int i = 1; i < FIR_LATENCY; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
            end
        end
    end

    assign enableFIRCoeff   = (state_q == S_LOAD_COEFF);
    assign busy             = (state_q != S_IDLE);
    assign blockDone        = (state_q == S_DONE);
    assign loadDataFlag     = load_q;
    assign stopDataLoadFlag = stop_q;
    assign firDataIn        = fir_q;
    assign sampleCount      = count_q;
    assign coeffError       = err_q;
    assign dataOutValid     = vpipe_q[FIR_LATENCY-1];
    assign stateDbg         = state_q;

endmodule

// File: doc/fir_stream_controller.md
FIR_STREAM_CONTROLLER -- requirements
Module: fir_stream_controller

Interface
REQ-001 The module SHALL provide parameter LENGTH, default 20: number of FIR taps.
REQ-002 The module SHALL provide parameter DATA_WIDTH, default 18: sample and coefficient width.
REQ-003 The module SHALL provide parameter NUMB_SAMPLES, default 60: input samples per block, range 1 to 255.
REQ-004 The module SHALL provide parameter FIR_LATENCY, default 2: cycles from a sample on firDataIn to its result on the FIR dataOut.
REQ-005 The module SHALL provide port clock, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 The module SHALL provide port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL provide port startBlock, input, 1 bit: one-cycle pulse starting a block.
REQ-008 The module SHALL provide port dataInValid, input, 1 bit: dataIn holds a valid sample this cycle.
REQ-009 The module SHALL provide port dataIn, input, DATA_WIDTH bits, signed: source sample.
REQ-010 The module SHALL provide port coeffSetFlag, input, 1 bit: the coefficient loader has finished.
REQ-011 The module SHALL provide port enableFIRCoeff, output, 1 bit: drives the loader enable and FIR loadCoeff.
REQ-012 The module SHALL provide port loadDataFlag, output, 1 bit: FIR shifts in firDataIn this cycle.
REQ-013 The module SHALL provide port stopDataLoadFlag, output, 1 bit: end-of-block marker to the FIR.
REQ-014 The module SHALL provide port firDataIn, output, DATA_WIDTH bits, signed: sample to the FIR.
REQ-015 The module SHALL provide port dataOutValid, output, 1 bit: FIR dataOut is valid this cycle.
REQ-016 The module SHALL provide port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The module SHALL provide port blockDone, output, 1 bit: one-cycle pulse when a block completes.
REQ-018 The module SHALL provide port sampleCount, output, 8 bits: number of samples accepted in the current block.
REQ-019 The module SHALL provide port coeffError, output, 1 bit: sticky coefficient-load timeout flag.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD_COEFF, STREAM, FLUSH, DRAIN and DONE.
REQ-021 IDLE: startBlock high SHALL cause a transition to LOAD_COEFF next cycle; startBlock SHALL be ignored in all other states.
REQ-022 LOAD_COEFF: enableFIRCoeff SHALL be high; on coeffSetFlag high, enableFIRCoeff SHALL drop the following cycle and the state SHALL become STREAM.
REQ-023 STREAM, per cycle with dataInValid high: firDataIn <= dataIn, loadDataFlag <= 1, sampleCount increments.
REQ-024 STREAM, per cycle with dataInValid low: loadDataFlag <= 0 and firDataIn holds; this is a stall, not an error.
REQ-025 When sample NUMB_SAMPLES is accepted, the FSM SHALL enter FLUSH next cycle; sampleCount SHALL saturate at NUMB_SAMPLES.
REQ-026 FLUSH: exactly LENGTH-1 zero samples SHALL be driven with loadDataFlag high, ignoring dataInValid; stopDataLoadFlag SHALL pulse on the last flush cycle.
REQ-027 DRAIN: the FSM SHALL wait FIR_LATENCY cycles, then enter DONE.
REQ-028 DONE: blockDone SHALL be high for one cycle, then the FSM SHALL return to IDLE with sampleCount cleared on entry to IDLE.
REQ-029 dataOutValid SHALL equal loadDataFlag delayed by exactly FIR_LATENCY cycles through a shift register, giving NUMB_SAMPLES+LENGTH-1 valid pulses per block.
REQ-030 An in-flight valid pipeline SHALL keep shifting across all state transitions.

Reset
REQ-031 While resetN is low at a rising edge: state IDLE; all outputs 0, including firDataIn; sampleCount 0; coeffError 0; valid pipeline cleared.
REQ-032 Reset asserted mid-block SHALL abort the block with no blockDone pulse; the next startBlock SHALL reload coefficients.

Configuration
REQ-033 With macro FIR_CTRL_COEFF_TIMEOUT_EN defined, a LOAD_COEFF dwell of 4*LENGTH cycles without coeffSetFlag SHALL set coeffError, drop enableFIRCoeff and return to IDLE; coeffError SHALL clear only on reset or the next startBlock.
REQ-034 Without FIR_CTRL_COEFF_TIMEOUT_EN, LOAD_COEFF SHALL wait indefinitely and coeffError SHALL be tied to 0.

Verification
REQ-035 Reset then a startBlock pulse -> enableFIRCoeff high next cycle; it falls one cycle after coeffSetFlag.
REQ-036 60 back-to-back valid samples (20 x 131071, 20 x -131072, 20 mixed) -> 79 loadDataFlag cycles, last 19 with firDataIn=0, then blockDone; 79 dataOutValid pulses, first 2 cycles after first load.
REQ-037 Deassert dataInValid for 5 cycles at sample 30 -> loadDataFlag low for 5 cycles, sampleCount holds at 30, total valid count still 79.
REQ-038 Assert resetN low during FLUSH -> all outputs 0 next cycle, no blockDone; a new startBlock completes a normal block.
REQ-039 startBlock pulsed during STREAM -> no effect, sampleCount unaffected.
REQ-040 Timeout macro defined, coeffSetFlag held 0 -> coeffError=1 after 80 cycles, busy=0; macro undefined -> busy stays 1.
